// File: rtl/serial_pair_serializer.sv
// Parallel-to-serial transmitter for operand pairs with first/last word framing.
// Define SERIAL_PAIR_LSB_FIRST_EN to shift out bit 0 first instead of the MSB.
module serial_pair_serializer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         a,
    output logic         b,
    output logic         first,
    output logic         last
);
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_d;
    logic [W-1:0]   sa, sb, sa_d, sb_d, sa_nx, sb_nx;
    logic [CW-1:0]  cnt, cnt_d;
    logic           out_valid_d, a_d, b_d, first_d, last_d;
    logic           accept, xfer;

    assign in_ready = rst & ((state == IDLE) | (out_valid & out_ready & last));
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;

`ifdef SERIAL_PAIR_LSB_FIRST_EN
    assign sa_nx = sa >> 1;
    assign sb_nx = sb >> 1;
`else
    assign sa_nx = sa << 1;
    assign sb_nx = sb << 1;
`endif

    always_comb begin
        state_d     = state;
        sa_d        = sa;
        sb_d        = sb;
        cnt_d       = cnt;
        out_valid_d = out_valid;
        a_d         = a;
        b_d         = b;
        first_d     = first;
        last_d      = last;

        // A finishing word and a new accept share the cycle, so the load wins.
        if (accept) begin
            state_d     = SHIFT;
            sa_d        = in_a;
            sb_d        = in_b;
            cnt_d       = CW'(W);
            out_valid_d = 1'b1;
`ifdef SERIAL_PAIR_LSB_FIRST_EN
            a_d         = in_a[0];
            b_d         = in_b[0];
`else
            a_d         = in_a[W-1];
            b_d         = in_b[W-1];
`endif
            first_d     = 1'b1;
            last_d      = (W == 1);
        end else if (state == SHIFT && xfer) begin
            if (last) begin
                state_d     = IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b0;
                a_d         = 1'b0;
                b_d         = 1'b0;
                first_d     = 1'b0;
                last_d      = 1'b0;
            end else begin
                sa_d    = sa_nx;
                sb_d    = sb_nx;
                cnt_d   = cnt - 1'b1;
`ifdef SERIAL_PAIR_LSB_FIRST_EN
                a_d     = sa_nx[0];
                b_d     = sb_nx[0];
`else
                a_d     = sa_nx[W-1];
                b_d     = sb_nx[W-1];
`endif
                first_d = 1'b0;
                last_d  = (cnt == CW'(2));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            a         <= 1'b0;
            b         <= 1'b0;
            first     <= 1'b0;
            last      <= 1'b0;
        end else begin
            state     <= state_d;
            sa        <= sa_d;
            sb        <= sb_d;
            cnt       <= cnt_d;
            out_valid <= out_valid_d;
            a         <= a_d;
            b         <= b_d;
            first     <= first_d;
            last      <= last_d;
        end
    end
endmodule

// File: tb/tb_serial_pair_serializer.sv
// Randomized bench for serial_pair_serializer against a queue-of-bits reference model.
// Honours SERIAL_PAIR_LSB_FIRST_EN for the expected bit order.
module tb_serial_pair_serializer;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         a, b, first, last;

    int n_tests = 0;
    int n_fail  = 0;

    // Each entry is {a, b, first, last} for one pending bit; q[0] is on the outputs.
    logic [3:0] q[$];
    logic       exp_ready;

    serial_pair_serializer #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .first(first), .last(last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] wa, input logic [W-1:0] wb);
        for (int i = 0; i < W; i++) begin
`ifdef SERIAL_PAIR_LSB_FIRST_EN
            int idx = i;
`else
            int idx = W - 1 - i;
`endif
            q.push_back({wa[idx], wb[idx], i == 0, i == W - 1});
        end
    endtask

    // Inputs only change just after a rising edge, so they are stable here.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_bits", {a, b, first, last}, 4'b0000);
            q.delete();
        end else begin
            exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) check("bits", {a, b, first, last}, q[0]);
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && exp_ready) push_word(in_a, in_b);
        end
    end

    task automatic send(input logic [W-1:0] wa, input logic [W-1:0] wb);
        int waited = 0;
        in_valid = 1'b1;
        in_a     = wa;
        in_b     = wb;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                check("accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        idle(3);
        rst = 1'b1;
        out_ready = 1'b1;
        idle(1);
        check("ready_after_rst", in_ready, 1);

        // Directed pattern, then back-to-back words with no gap.
        send(8'h64, 8'h62);
        idle(10);
        send(8'hFF, 8'h00);
        send(8'h00, 8'hFF);
        idle(18);

        // Stall for three cycles at bit 3.
        send(8'hA5, 8'h5A);
        idle(3);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
        idle(8);

        // Reset mid-word, then a fresh word.
        send(8'hC3, 8'h3C);
        idle(4);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        check("ready_after_midrst", in_ready, 1);
        send(8'h0F, 8'h0F);
        idle(10);

        // Random traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2 * W + 4);
        check("drained", q.size(), 0);
        check("final_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
